// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide controller: FSM encoding,
// divide iteration count, operation select encoding and an abs helper.
package mdu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

    localparam int MDU_DIV_ITERS = 32;
    localparam int MDU_CNT_W     = $clog2(MDU_DIV_ITERS);

    localparam logic MUL_SEL_MUL = 1'b1;
    localparam logic MUL_SEL_DIV = 1'b0;

    // Magnitude of a 32-bit operand; unsigned operands pass through.
    function automatic logic [31:0] mdu_abs(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mdu_ctrl_div_iter.sv
// One radix-2 restoring divide step: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_iter (
    input  logic [31:0] rem,
    input  logic [31:0] quot,
    input  logic [31:0] divisor,
    output logic [31:0] rem_nx,
    output logic [31:0] quot_nx
);

    logic [32:0] trial;
    logic [32:0] diff;

    // rem < divisor always holds, so a clear borrow bit means trial >= divisor.
    always_comb begin
        trial = {rem, quot[31]};
        diff  = trial - {1'b0, divisor};
        if (!diff[32]) begin
            rem_nx  = diff[31:0];
            quot_nx = {quot[30:0], 1'b1};
        end else begin
            rem_nx  = trial[31:0];
            quot_nx = {quot[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// MULT/MULTU/DIV/DIVU controller: one-cycle multiply, 32-step restoring divide.
// Define MDU_DIV0_FASTPATH_EN to finish divide-by-zero straight from IDLE.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_i,
    input  logic        mul_sel_i,
    input  logic        is_sign_i,
    input  logic [31:0] src_a_i,
    input  logic [31:0] src_b_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        busy_o
);

    mdu_state_e             state, state_nx;
    logic [MDU_CNT_W-1:0]   cnt;
    logic [31:0]            op_a, op_b;
    logic                   op_sign;
    logic [31:0]            rem, quot, dvs;
    logic [31:0]            rem_nx, quot_nx;
    logic [31:0]            q_fix, r_fix;
    logic [63:0]            ext_a, ext_b, prod;
    logic                   div_last, div_zero, q_neg, r_neg;

    div_iter u_div_iter (
        .rem     (rem),
        .quot    (quot),
        .divisor (dvs),
        .rem_nx  (rem_nx),
        .quot_nx (quot_nx)
    );

    // Low 64 bits of the extended product are correct for both sign modes.
    assign ext_a = {{32{op_sign & op_a[31]}}, op_a};
    assign ext_b = {{32{op_sign & op_b[31]}}, op_b};
    assign prod  = ext_a * ext_b;

    assign div_last = (cnt == MDU_CNT_W'(MDU_DIV_ITERS - 1));
    assign div_zero = (op_b == 32'd0);
    assign q_neg    = op_sign & (op_a[31] ^ op_b[31]);
    assign r_neg    = op_sign & op_a[31];
    assign q_fix    = q_neg ? (~quot_nx + 32'd1) : quot_nx;
    assign r_fix    = r_neg ? (~rem_nx + 32'd1) : rem_nx;

    always_ff @(posedge clk) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (flush_i) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (start_i) begin
                    if (mul_sel_i == MUL_SEL_MUL) state_nx = ST_MUL;
`ifdef MDU_DIV0_FASTPATH_EN
                    else if (src_b_i == 32'd0)    state_nx = ST_DONE;
`endif
                    else                          state_nx = ST_DIV;
                end
                ST_MUL:  state_nx = ST_DONE;
                ST_DIV:  if (div_last) state_nx = ST_DONE;
                ST_DONE: state_nx = ST_IDLE;
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        stall_o = 1'b0;
        done_o  = 1'b0;
        busy_o  = 1'b0;
        stall_o = resetn & ~flush_i &
                  ((state == ST_IDLE & start_i) | state == ST_MUL | state == ST_DIV);
        done_o  = (state == ST_DONE) & ~flush_i;
        busy_o  = (state != ST_IDLE);
    end

    // Operand latch, divide iteration and HI/LO result registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt     <= '0;
            op_a    <= '0;
            op_b    <= '0;
            op_sign <= 1'b0;
            rem     <= '0;
            quot    <= '0;
            dvs     <= '0;
            hi_o    <= '0;
            lo_o    <= '0;
        end else if (flush_i) begin
            cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start_i) begin
                    op_a    <= src_a_i;
                    op_b    <= src_b_i;
                    op_sign <= is_sign_i;
                    rem     <= '0;
                    quot    <= mdu_abs(src_a_i, is_sign_i);
                    dvs     <= mdu_abs(src_b_i, is_sign_i);
                    cnt     <= '0;
`ifdef MDU_DIV0_FASTPATH_EN
                    if (mul_sel_i == MUL_SEL_DIV && src_b_i == 32'd0) begin
                        hi_o <= src_a_i;
                        lo_o <= 32'hFFFF_FFFF;
                    end
`endif
                end
                ST_MUL: begin
                    hi_o <= prod[63:32];
                    lo_o <= prod[31:0];
                end
                ST_DIV: begin
                    rem  <= rem_nx;
                    quot <= quot_nx;
                    cnt  <= cnt + MDU_CNT_W'(1);
                    if (div_last) begin
                        // Signed overflow (MIN / -1) falls out of the abs path as 0x80000000.
                        hi_o <= div_zero ? op_a : r_fix;
                        lo_o <= div_zero ? 32'hFFFF_FFFF : q_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
